// File: rtl/fetch_controller_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for fetch_controller.
// master modport is the fetch controller; slave is its environment (memory + decode).
// No state lives here; it only groups the handshake and bus signals.
interface fetch_controller_if;
  logic        Start;
  logic [63:0] InstrAddress;
  logic [31:0] Instruction;
  logic        IfValid;
  logic [31:0] IfInstr;
  logic [63:0] IfPC;
  logic        IdReady;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        Halted;
  logic [31:0] FetchCount;

  modport master (
    input  Start, Instruction, IdReady, Redirect, RedirectPC,
    output InstrAddress, IfValid, IfInstr, IfPC, Halted, FetchCount
  );

  modport slave (
    output Start, Instruction, IdReady, Redirect, RedirectPC,
    input  InstrAddress, IfValid, IfInstr, IfPC, Halted, FetchCount
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing into a 2-entry {PC, instr} queue toward decode.
// Latency: Start -> first IfValid 2 cycles; one instruction per cycle when decode is ready.
// Backpressure: IdReady low holds the queue head; fetch stalls when the queue is full.
module fetch_controller #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] LAST_PC  = 64'h068
) (
  input  logic          CLOCK,
  input  logic          RESET,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [1:0]  count, count_nxt;
  logic [63:0] q0_pc, q1_pc, q0_pc_nxt, q1_pc_nxt;
  logic [31:0] q0_ins, q1_ins, q0_ins_nxt, q1_ins_nxt;
  logic [31:0] fetch_count;

  logic        pop;
  logic        flush;
  logic        past_end;
  logic        push;
  logic [1:0]  cnt_after_pop;

  // Low address bits of a branch target are dropped by word alignment.
  logic        unused_rpc_bits;
  assign unused_rpc_bits = &{1'b0, bus.RedirectPC[1:0]};

  // Handshake terms: a pop still completes in a redirect cycle, a push needs a free slot.
  assign pop           = (count != 2'd0) && bus.IdReady;
  assign cnt_after_pop = count - {1'b0, pop};
  assign flush         = bus.Redirect && (state != IDLE);
  assign past_end      = pc > LAST_PC;
  assign push          = (state == FETCH) && !flush && !past_end && (cnt_after_pop != 2'd2);

  // Next-state logic: Start leaves IDLE, reaching the last address halts, redirect re-enters FETCH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = FETCH;
      FETCH:   if (!flush && (past_end || (push && pc == LAST_PC))) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = FETCH;
  end

  // Queue and PC next values: shift on pop, append at the first free slot on push, clear on redirect.
  always_comb begin
    pc_nxt     = pc;
    count_nxt  = cnt_after_pop;
    q0_pc_nxt  = q0_pc;
    q0_ins_nxt = q0_ins;
    q1_pc_nxt  = q1_pc;
    q1_ins_nxt = q1_ins;
    if (pop) begin
      q0_pc_nxt  = q1_pc;
      q0_ins_nxt = q1_ins;
    end
    if (flush) begin
      pc_nxt    = {bus.RedirectPC[63:2], 2'b00};
      count_nxt = 2'd0;
    end else if (push) begin
      pc_nxt    = pc + 64'd4;
      count_nxt = cnt_after_pop + 2'd1;
      if (cnt_after_pop == 2'd0) begin
        q0_pc_nxt  = pc;
        q0_ins_nxt = bus.Instruction;
      end else begin
        q1_pc_nxt  = pc;
        q1_ins_nxt = bus.Instruction;
      end
    end
  end

  // State, PC, queue and accepted-instruction counter registers; reset empties the queue.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      count       <= 2'd0;
      q0_pc       <= 64'h0;
      q1_pc       <= 64'h0;
      q0_ins      <= 32'h0;
      q1_ins      <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      count  <= count_nxt;
      q0_pc  <= q0_pc_nxt;
      q1_pc  <= q1_pc_nxt;
      q0_ins <= q0_ins_nxt;
      q1_ins <= q1_ins_nxt;
      if (pop && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
    end
  end

  // Outputs come straight from registers; head fields read as zero while the queue is empty.
  assign bus.InstrAddress = pc;
  assign bus.IfValid      = (count != 2'd0);
  assign bus.IfInstr      = (count != 2'd0) ? q0_ins : 32'h0;
  assign bus.IfPC         = (count != 2'd0) ? q0_pc : 64'h0;
  assign bus.Halted       = (state == HALT) && (count == 2'd0);
  assign bus.FetchCount   = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_controller;
  localparam logic [63:0] LAST = 64'h068;

  logic CLOCK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  fetch_controller_if bus ();

  fetch_controller #(.RESET_PC(64'h0), .LAST_PC(LAST)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Instruction memory contents: two fixed words, a scrambled pattern elsewhere.
  function automatic logic [31:0] rom(input logic [63:0] a);
    if (a == 64'h0) return 32'hF84003E9;
    if (a == 64'h4) return 32'hF84083EA;
    return (a[31:0] * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  assign bus.Instruction = rom(bus.InstrAddress);

  // Reference model: fetch mode (0 idle, 1 fetching, 2 halted), next address, queue of fetched PCs.
  int          m_mode;
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  logic [31:0] m_fc;

  task automatic model_step();
    bit popped;
    if (!RESET) begin
      m_mode = 0; m_pc = 64'h0; m_q.delete(); m_fc = 32'h0;
      return;
    end
    popped = (m_q.size() > 0) && bus.IdReady;
    if (popped) begin
      void'(m_q.pop_front());
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end
    if (m_mode == 0) begin
      if (bus.Start) m_mode = 1;
    end else if (bus.Redirect) begin
      m_q.delete();
      m_pc   = {bus.RedirectPC[63:2], 2'b00};
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_pc > LAST) m_mode = 2;
      else if (m_q.size() < 2) begin
        m_q.push_back(m_pc);
        if (m_pc == LAST) m_mode = 2;
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start = 0; bus.IdReady = 0; bus.Redirect = 0; bus.RedirectPC = 64'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 0; tick(); RESET = 1;
  endtask

  task automatic test_reset();
    RESET = 0; idle_inputs();
    tick(); tick();
    checks++; if (bus.InstrAddress !== 64'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.InstrAddress); end
    checks++; if (bus.IfValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.IfValid); end
    checks++; if (bus.IfInstr !== 32'h0 || bus.IfPC !== 64'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", bus.IfInstr, bus.IfPC); end
    checks++; if (bus.Halted !== 1'b0 || bus.FetchCount !== 32'h0) begin errors++; $display("FAIL reset_halt_cnt got %b/%0d exp 0/0", bus.Halted, bus.FetchCount); end
    RESET = 1;
  endtask

  task automatic test_first_fetch();
    do_reset();
    bus.Start = 1; bus.IdReady = 1;
    tick(); bus.Start = 0;
    checks++; if (bus.IfValid !== 1'b0) begin errors++; $display("FAIL first_early_valid got %b exp 0", bus.IfValid); end
    tick();
    checks++; if (bus.IfValid !== 1'b1 || bus.IfPC !== 64'h0 || bus.IfInstr !== 32'hF84003E9)
      begin errors++; $display("FAIL first_head0 got v=%b pc=%h ins=%h exp 1/0/F84003E9", bus.IfValid, bus.IfPC, bus.IfInstr); end
    tick();
    checks++; if (bus.IfValid !== 1'b1 || bus.IfPC !== 64'h4 || bus.IfInstr !== 32'hF84083EA)
      begin errors++; $display("FAIL first_head4 got v=%b pc=%h ins=%h exp 1/4/F84083EA", bus.IfValid, bus.IfPC, bus.IfInstr); end
    checks++; if (bus.FetchCount !== 32'd1) begin errors++; $display("FAIL first_count got %0d exp 1", bus.FetchCount); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    do_reset();
    bus.Start = 1; bus.IdReady = 0;
    tick(); bus.Start = 0;
    tick(); tick(); tick();
    checks++; if (bus.IfPC !== 64'h0 || bus.IfValid !== 1'b1) begin errors++; $display("FAIL bp_head got %h/%b exp 0/1", bus.IfPC, bus.IfValid); end
    checks++; if (bus.InstrAddress !== 64'h8) begin errors++; $display("FAIL bp_addr got %h exp 8", bus.InstrAddress); end
    bus.IdReady = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      exp_pc = 64'(4 * i);
      checks++; if (bus.IfPC !== exp_pc || bus.IfInstr !== rom(exp_pc))
        begin errors++; $display("FAIL bp_order[%0d] got %h/%h exp %h/%h", i, bus.IfPC, bus.IfInstr, exp_pc, rom(exp_pc)); end
    end
    checks++; if (bus.FetchCount !== 32'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", bus.FetchCount); end
    bus.IdReady = 0;
    tick();
  endtask

  // Continues from a full queue left by test_backpressure.
  task automatic test_redirect();
    bus.Redirect = 1; bus.RedirectPC = 64'h02E;
    tick();
    bus.Redirect = 0;
    checks++; if (bus.IfValid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", bus.IfValid); end
    checks++; if (bus.InstrAddress !== 64'h02C) begin errors++; $display("FAIL redir_addr got %h exp 2c", bus.InstrAddress); end
    tick();
    checks++; if (bus.IfValid !== 1'b1 || bus.IfPC !== 64'h02C) begin errors++; $display("FAIL redir_head got %b/%h exp 1/2c", bus.IfValid, bus.IfPC); end
  endtask

  task automatic test_free_run();
    logic [63:0] last_pc;
    bit done;
    last_pc = 64'hDEAD; done = 0;
    do_reset();
    bus.Start = 1; bus.IdReady = 1;
    tick(); bus.Start = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.IfValid) last_pc = bus.IfPC;
      if (bus.Halted) done = 1; else tick();
    end
    checks++; if (!done) begin errors++; $display("FAIL run_halt got 0 exp 1 within 100 cycles"); end
    checks++; if (last_pc !== LAST) begin errors++; $display("FAIL run_last_pc got %h exp %h", last_pc, LAST); end
    checks++; if (bus.FetchCount !== 32'd27) begin errors++; $display("FAIL run_count got %0d exp 27", bus.FetchCount); end
    checks++; if (bus.InstrAddress !== 64'h06C) begin errors++; $display("FAIL run_addr got %h exp 6c", bus.InstrAddress); end
  endtask

  // Continues from the halted state left by test_free_run.
  task automatic test_halt_redirect();
    bus.Redirect = 1; bus.RedirectPC = 64'h0;
    tick();
    bus.Redirect = 0;
    checks++; if (bus.Halted !== 1'b0 || bus.InstrAddress !== 64'h0) begin errors++; $display("FAIL hredir got halt=%b addr=%h exp 0/0", bus.Halted, bus.InstrAddress); end
    tick();
    checks++; if (bus.IfValid !== 1'b1 || bus.IfPC !== 64'h0) begin errors++; $display("FAIL hredir_head got %b/%h exp 1/0", bus.IfValid, bus.IfPC); end
    tick(); tick();
    RESET = 0;
    tick();
    RESET = 1;
    checks++; if (bus.IfValid !== 1'b0 || bus.IfPC !== 64'h0 || bus.IfInstr !== 32'h0)
      begin errors++; $display("FAIL midreset_head got %b/%h/%h exp 0/0/0", bus.IfValid, bus.IfPC, bus.IfInstr); end
    checks++; if (bus.FetchCount !== 32'h0 || bus.InstrAddress !== 64'h0 || bus.Halted !== 1'b0)
      begin errors++; $display("FAIL midreset_state got cnt=%0d addr=%h halt=%b exp 0/0/0", bus.FetchCount, bus.InstrAddress, bus.Halted); end
  endtask

  task automatic test_random();
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_vld, e_halt;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      RESET          = ($urandom_range(0, 299) != 0);
      bus.Start      = ($urandom_range(0, 7) == 0);
      bus.IdReady    = ($urandom_range(0, 3) != 0);
      bus.Redirect   = ($urandom_range(0, 19) == 0);
      bus.RedirectPC = ($urandom_range(0, 9) == 0) ? {32'hFFFF_FFFF, $urandom()} : 64'($urandom_range(0, 135));
      tick();
      e_vld  = (m_q.size() != 0);
      e_pc   = e_vld ? m_q[0] : 64'h0;
      e_ins  = e_vld ? rom(m_q[0]) : 32'h0;
      e_halt = (m_mode == 2) && !e_vld;
      checks++; if (bus.IfValid !== e_vld || bus.IfPC !== e_pc || bus.IfInstr !== e_ins)
        begin errors++; $display("FAIL rand_head cyc %0d got %b/%h/%h exp %b/%h/%h", cyc, bus.IfValid, bus.IfPC, bus.IfInstr, e_vld, e_pc, e_ins); end
      checks++; if (bus.InstrAddress !== m_pc) begin errors++; $display("FAIL rand_addr cyc %0d got %h exp %h", cyc, bus.InstrAddress, m_pc); end
      checks++; if (bus.Halted !== e_halt) begin errors++; $display("FAIL rand_halt cyc %0d got %b exp %b", cyc, bus.Halted, e_halt); end
      checks++; if (bus.FetchCount !== m_fc) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", cyc, bus.FetchCount, m_fc); end
    end
  endtask

  initial begin
    RESET = 0;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_free_run();
    test_halt_redirect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
Parameters:
REQ-001 RESET_PC, 64'h0, PC value loaded at reset.
REQ-002 LAST_PC, 64'h068, highest address fetched before halting.
Ports:
REQ-003 CLOCK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-low reset.
REQ-005 Start  in  1  begins fetching; honoured only in IDLE.
REQ-006 InstrAddress  out  64  address to combinational instruction memory; equals PC register at all times.
REQ-007 Instruction  in  32  instruction word for InstrAddress, valid in the same cycle.
REQ-008 IfValid  out  1  fetch queue head valid toward decode.
REQ-009 IfInstr  out  32  instruction at queue head; 32'h0 when empty.
REQ-010 IfPC  out  64  address of queue head; 64'h0 when empty.
REQ-011 IdReady  in  1  decode accepts head this cycle.
REQ-012 Redirect  in  1  branch taken; flush and refetch.
REQ-013 RedirectPC  in  64  branch target address.
REQ-014 Halted  out  1  fetch finished and queue drained.
REQ-015 FetchCount  out  32  instructions accepted by decode since reset, saturating.

Function
REQ-016 States SHALL be IDLE, FETCH, HALT; PC register 64 bits; fetch queue exactly 2 entries of {PC, Instruction}, FIFO order.
REQ-017 IDLE: no push; Start=1 -> FETCH next cycle, first push occurs in that FETCH cycle.
REQ-018 FETCH push condition: (queue count < 2, or count = 2 with a pop this cycle) and no Redirect; push stores {PC, Instruction}, PC <= PC + 4.
REQ-019 PC addition SHALL wrap modulo 2^64.
REQ-020 Push of PC = LAST_PC -> HALT next cycle; PC > LAST_PC in FETCH (after redirect) -> HALT without push.
REQ-021 Pop occurs when IfValid=1 and IdReady=1; IfValid/IfInstr/IfPC driven from registered queue head, no combinational path from Instruction.
REQ-022 Simultaneous push and pop at count 1 or 2 SHALL keep count unchanged and preserve order.
REQ-023 No pop when empty; IdReady while empty has no effect.
REQ-024 Redirect=1 in FETCH or HALT: a pop in that cycle still completes, all remaining entries discarded, count <= 0, PC <= {RedirectPC[63:2], 2'b00}, state <= FETCH, no push that cycle.
REQ-025 Redirect in IDLE SHALL be ignored; Start in FETCH/HALT SHALL be ignored.
REQ-026 Redirect has priority over push; reset has priority over Redirect and Start.
REQ-027 HALT: no pushes; queue drains normally; Halted = 1 iff state HALT and count = 0.
REQ-028 FetchCount increments by 1 per pop, holds at 32'hFFFFFFFF.
REQ-029 Throughput: with IdReady held 1, one instruction per cycle from second FETCH cycle on; latency Start -> first IfValid = 2 cycles.

Reset
REQ-030 On RESET=0 at a rising edge: PC <= RESET_PC, state <= IDLE, count <= 0, IfValid <= 0, IfInstr <= 0, IfPC <= 0, Halted <= 0, FetchCount <= 0.
REQ-031 Reset mid-operation SHALL discard all queued entries; no pop counted in the reset cycle.

Verification
REQ-032 Reset, Start pulse, IdReady=1, ROM 0->F84003E9, 4->F84083EA -> IfValid at cycle 2 with IfPC 0/IfInstr F84003E9, next cycle IfPC 4/F84083EA.
REQ-033 IdReady=0 after Start -> queue fills with PC 0 and 4, InstrAddress holds 8; IdReady=1 -> heads 0,4,8 in order, no loss or duplicate.
REQ-034 Redirect with RedirectPC=64'h02E while queue holds 2 entries -> queue flushed, InstrAddress 64'h02C next cycle, next IfPC 64'h02C.
REQ-035 LAST_PC=64'h068 free run -> final IfPC 64'h068, Halted=1 after it pops, FetchCount=27, InstrAddress 64'h06C.
REQ-036 Redirect to 64'h000 while HALT -> Halted drops, fetching resumes from 0; RESET=0 mid-stream -> all outputs reset values next cycle.
